avalon_mm_burst_master: RTL and testbench
=========================================

AVALON_MM_BURST_MASTER -- requirements
Module: avalon_mm_burst_master

Interface
REQ-001 Parameter DATA_W, default 32: Avalon data width in bits, a multiple of 8.
REQ-002 Parameter ADDR_W, default 32: byte address width.
REQ-003 Parameter BURST_W, default 4: BURSTCOUNT width; maximum burst is 2^BURST_W-1 beats.
REQ-004 Parameter TIMEOUT, default 1024: idle-bus cycles tolerated before abort; 0 disables the timeout.
REQ-005 Ports: CLK  in  1  sole clock; all logic is on the rising edge.
REQ-006 Ports: RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-007 Ports: ADDRESS  out  ADDR_W  burst start address; BURSTCOUNT  out  BURST_W  beats in the burst.
REQ-008 Ports: READ  out  1, WRITE  out  1, WRITEDATA  out  DATA_W, BYTEENABLE  out  DATA_W/8.
REQ-009 Ports: WAITREQUEST  in  1, READDATA  in  DATA_W, READDATAVALID  in  1.
REQ-010 Ports: LOCK  out  1  high while a burst is owned.
REQ-011 Ports: start  in  1, rnw  in  1, address_to_access  in  ADDR_W, burst_len  in  BURST_W, byte_en  in  DATA_W/8.
REQ-012 Ports: wr_data  in  DATA_W, wr_valid  in  1, wr_ready  out  1 (write-beat stream).
REQ-013 Ports: rd_data  out  DATA_W, rd_valid  out  1 (read-beat stream, no backpressure).
REQ-014 Ports: busy  out  1, done  out  1, error  out  1.

Function
REQ-015 States are IDLE, WR_BURST, RD_CMD, RD_DATA and DONE.
REQ-016 ADDRESS, BURSTCOUNT, BYTEENABLE, READ and rd_* are registered.
REQ-017 In IDLE, start=1 latches address_to_access, rnw, burst_len and byte_en.
REQ-018 burst_len=0 is treated as 1.
REQ-019 On that start the block goes to WR_BURST (rnw=0) or RD_CMD (rnw=1) on the next edge.
REQ-020 start is ignored whenever busy=1.
REQ-021 busy=1 in every state other than IDLE.
REQ-022 LOCK=1 in WR_BURST, RD_CMD and RD_DATA only.
REQ-023 ADDRESS, BURSTCOUNT and BYTEENABLE hold their latched values, constant, for the whole burst.
REQ-024 WR_BURST: WRITE = wr_valid (combinational); WRITEDATA = wr_data; wr_ready = !WAITREQUEST.
REQ-025 A write beat is accepted on a cycle with WRITE=1 and WAITREQUEST=0.
REQ-026 The beat counter decrements on each accepted beat; the last beat moves the block to DONE.
REQ-027 WRITE and wr_ready are 0 outside WR_BURST.
REQ-028 RD_CMD: READ=1 until a cycle with WAITREQUEST=0, then move to RD_DATA with READ=0.
REQ-029 RD_DATA: each READDATAVALID=1 gives rd_data=READDATA and rd_valid=1 one cycle later (latency 1).
REQ-030 The last read beat moves the block to DONE.
REQ-031 READDATAVALID in RD_CMD in the same cycle as the command acceptance is counted as beat 1.
REQ-032 READDATAVALID in IDLE, WR_BURST or DONE is ignored; rd_valid stays 0.
REQ-033 DONE lasts exactly one cycle with done=1, then the block returns to IDLE.
REQ-034 A new start can be accepted in the cycle after DONE.
REQ-035 Timeout counter clears on any accepted beat or command and on entry to WR_BURST/RD_CMD; it increments on every other busy cycle.
REQ-036 When the timeout counter reaches TIMEOUT (TIMEOUT>0), READ/WRITE drop, the block goes to DONE, and error=1 for the DONE cycle.
REQ-037 error is 0 on a normally completed burst.
REQ-038 Beat counter width is BURST_W; it shall never wrap below zero.

Reset
REQ-039 RESET_N=0 forces IDLE immediately, regardless of clock.
REQ-040 During reset, all outputs are 0, including ADDRESS, BURSTCOUNT, BYTEENABLE, rd_data, LOCK, busy, done and error.
REQ-041 Reset mid-burst abandons the burst with no done pulse.
REQ-042 The first start is accepted on the first rising edge with RESET_N=1.

Verification
REQ-043 Write burst: rnw=0, addr 0x100, len 4, wr_valid always 1, WAITREQUEST=0. Required: WRITE high 4 cycles, BURSTCOUNT=4, ADDRESS=0x100 throughout, done pulse on cycle 5.
REQ-044 Write stall: WAITREQUEST=1 for 3 cycles on beat 2, and wr_valid=0 for 2 cycles on beat 3. Required: exactly 4 beats accepted, WRITEDATA stable while stalled.
REQ-045 Read burst: len 8, READ held through 2 WAITREQUEST cycles, then 8 READDATAVALID beats with gaps. Required: 8 rd_valid pulses, each 1 cycle after its beat, data in order, then done.
REQ-046 Timeout: TIMEOUT=16, read with WAITREQUEST stuck high. Required: READ drops after 16 cycles, done=1 and error=1 together, back in IDLE.
REQ-047 Corners: burst_len=0 (one beat), start while busy (ignored), RESET_N low mid-burst (all outputs 0, no done), start on the cycle after done (accepted).

Source files
------------

// File: rtl/avalon_mm_burst_master_if.sv
`default_nettype none
// ============================================================================
// Module   : avalon_mm_burst_master_if
// Brief    : Avalon-MM burst bus bundle between a burst master and its slave.
// Revision : 1.0 - initial release
// ============================================================================

interface avalon_mm_burst_master_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int BURST_W = 4
);
    logic [ADDR_W-1:0]   ADDRESS;
    logic [BURST_W-1:0]  BURSTCOUNT;
    logic                READ;
    logic                WRITE;
    logic [DATA_W-1:0]   WRITEDATA;
    logic [DATA_W/8-1:0] BYTEENABLE;
    logic                LOCK;
    logic                WAITREQUEST;
    logic [DATA_W-1:0]   READDATA;
    logic                READDATAVALID;

    modport master (
        output ADDRESS,
        output BURSTCOUNT,
        output READ,
        output WRITE,
        output WRITEDATA,
        output BYTEENABLE,
        output LOCK,
        input  WAITREQUEST,
        input  READDATA,
        input  READDATAVALID
    );

    modport slave (
        input  ADDRESS,
        input  BURSTCOUNT,
        input  READ,
        input  WRITE,
        input  WRITEDATA,
        input  BYTEENABLE,
        input  LOCK,
        output WAITREQUEST,
        output READDATA,
        output READDATAVALID
    );
endinterface

`default_nettype wire

// File: rtl/avalon_mm_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : avalon_mm_burst_master
// Brief    : Single-burst Avalon-MM master with write/read beat streams,
//            bus lock and an idle-bus timeout.
// Revision : 1.0 - initial release
// ============================================================================

module avalon_mm_burst_master #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int BURST_W = 4,
    parameter int TIMEOUT = 1024
) (
    input  wire logic                CLK,
    input  wire logic                RESET_N,

    avalon_mm_burst_master_if.master av,

    input  wire logic                start,
    input  wire logic                rnw,
    input  wire logic [ADDR_W-1:0]   address_to_access,
    input  wire logic [BURST_W-1:0]  burst_len,
    input  wire logic [DATA_W/8-1:0] byte_en,

    input  wire logic [DATA_W-1:0]   wr_data,
    input  wire logic                wr_valid,
    output logic                     wr_ready,

    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,

    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    // The timeout counter only has to reach TIMEOUT-1: the abort fires on the
    // idle cycle that would have made it TIMEOUT.
    localparam int                TMO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit                c_TMO_EN   = (TIMEOUT > 0);
    localparam logic [TMO_W-1:0]  c_TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_BURST = 3'd1,
        S_RD_CMD   = 3'd2,
        S_RD_DATA  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t               r_state;
    logic [BURST_W-1:0]   r_beats;
    logic [TMO_W-1:0]     r_tmo;
    logic                 r_error;
    logic                 r_read;
    logic [ADDR_W-1:0]    r_address;
    logic [BURST_W-1:0]   r_burstcount;
    logic [DATA_W/8-1:0]  r_byteenable;
    logic [DATA_W-1:0]    r_rd_data;
    logic                 r_rd_valid;

    logic                 w_in_wr;
    logic                 w_in_rd_cmd;
    logic                 w_in_rd_data;
    logic                 w_active;
    logic                 w_wr_accept;
    logic                 w_cmd_accept;
    logic                 w_rd_beat;
    logic                 w_beat;
    logic                 w_progress;
    logic                 w_last;
    logic                 w_tmo_hit;
    logic [BURST_W-1:0]   w_len_eff;

    assign w_in_wr      = (r_state == S_WR_BURST);
    assign w_in_rd_cmd  = (r_state == S_RD_CMD);
    assign w_in_rd_data = (r_state == S_RD_DATA);
    assign w_active     = w_in_wr | w_in_rd_cmd | w_in_rd_data;

    assign w_wr_accept  = w_in_wr & wr_valid & ~av.WAITREQUEST;
    assign w_cmd_accept = w_in_rd_cmd & ~av.WAITREQUEST;
    // A beat returned together with command acceptance counts as the first one.
    assign w_rd_beat    = av.READDATAVALID & (w_cmd_accept | w_in_rd_data);
    assign w_beat       = w_wr_accept | w_rd_beat;
    assign w_progress   = w_wr_accept | w_cmd_accept | w_rd_beat;
    assign w_last       = w_beat & (r_beats == BURST_W'(1));
    assign w_tmo_hit    = c_TMO_EN & w_active & ~w_progress & (r_tmo == c_TMO_LAST);

    assign w_len_eff    = (burst_len == '0) ? BURST_W'(1) : burst_len;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= S_IDLE;
            r_beats      <= '0;
            r_tmo        <= '0;
            r_error      <= 1'b0;
            r_read       <= 1'b0;
            r_address    <= '0;
            r_burstcount <= '0;
            r_byteenable <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_error    <= 1'b0;

            if (w_rd_beat) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= av.READDATA;
            end

            if (w_beat && (r_beats != '0)) begin
                r_beats <= r_beats - BURST_W'(1);
            end

            if (w_progress) begin
                r_tmo <= '0;
            end else if (w_active && c_TMO_EN) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_address    <= address_to_access;
                        r_burstcount <= w_len_eff;
                        r_beats      <= w_len_eff;
                        r_byteenable <= byte_en;
                        r_tmo        <= '0;
                        r_read       <= rnw;
                        r_state      <= rnw ? S_RD_CMD : S_WR_BURST;
                    end
                end
                S_WR_BURST: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else if (w_tmo_hit) begin
                        r_state <= S_DONE;
                        r_error <= 1'b1;
                    end
                end
                S_RD_CMD: begin
                    if (w_cmd_accept) begin
                        r_read  <= 1'b0;
                        r_state <= w_last ? S_DONE : S_RD_DATA;
                    end else if (w_tmo_hit) begin
                        r_read  <= 1'b0;
                        r_state <= S_DONE;
                        r_error <= 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else if (w_tmo_hit) begin
                        r_state <= S_DONE;
                        r_error <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign av.ADDRESS    = r_address;
    assign av.BURSTCOUNT = r_burstcount;
    assign av.BYTEENABLE = r_byteenable;
    assign av.READ       = r_read;
    assign av.WRITE      = w_in_wr & wr_valid;
    // Gated so the bus shows zero data outside the write burst and in reset.
    assign av.WRITEDATA  = w_in_wr ? wr_data : '0;
    assign av.LOCK       = w_active;

    assign wr_ready      = w_in_wr & ~av.WAITREQUEST;
    assign rd_data       = r_rd_data;
    assign rd_valid      = r_rd_valid;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign error         = r_error;

endmodule

`default_nettype wire

// File: tb/tb_avalon_mm_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_mm_burst_master
// Brief    : Directed + randomized bench for avalon_mm_burst_master with a
//            queue-based slave/stream reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_avalon_mm_burst_master;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int BURST_W = 4;
    localparam int TIMEOUT = 16;

    logic        CLK     = 1'b0;
    logic        RESET_N = 1'b0;
    logic        start   = 1'b0;
    logic        rnw     = 1'b0;
    logic [31:0] address_to_access = '0;
    logic [3:0]  burst_len = '0;
    logic [3:0]  byte_en   = '0;
    logic [31:0] wr_data   = '0;
    logic        wr_valid  = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    avalon_mm_burst_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

    avalon_mm_burst_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .av(bus),
        .start(start), .rnw(rnw), .address_to_access(address_to_access),
        .burst_len(burst_len), .byte_en(byte_en),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done), .error(error)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Randomize every request-side input that the DUT must ignore right now.
    task automatic scramble(input bit rand_start);
        start             = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
        rnw               = 1'($urandom_range(0, 1));
        address_to_access = $urandom;
        burst_len         = 4'($urandom);
        byte_en           = 4'($urandom);
        wr_valid          = 1'($urandom_range(0, 1));
        wr_data           = $urandom;
    endtask

    task automatic burst_checks(input string tag, input logic [31:0] addr, input int len, input logic [3:0] be);
        check({tag, "_hold"}, {bus.ADDRESS, bus.BURSTCOUNT, bus.BYTEENABLE}, {addr, len[3:0], be});
        check({tag, "_stat"}, {busy, bus.LOCK, done, error}, 4'b1100);
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, "_addr"},  bus.ADDRESS, 0);
        check({tag, "_ctl"},   {bus.BURSTCOUNT, bus.BYTEENABLE, bus.READ, bus.WRITE, bus.LOCK,
                                wr_ready, rd_valid, busy, done, error}, 0);
        check({tag, "_wdata"}, bus.WRITEDATA, 0);
        check({tag, "_rdata"}, rd_data, 0);
    endtask

    // Idle cycle that presents a new request; also releases reset.
    task automatic start_step(input logic r, input logic [31:0] addr, input int len_in, input logic [3:0] be);
        @(negedge CLK);
        scramble(1'b0);
        RESET_N           = 1'b1;
        start             = 1'b1;
        rnw               = r;
        address_to_access = addr;
        burst_len         = len_in[3:0];
        byte_en           = be;
        bus.WAITREQUEST   = 1'($urandom_range(0, 1));
        bus.READDATAVALID = 1'($urandom_range(0, 1));
        bus.READDATA      = $urandom;
        #1;
        check("idle_state", {busy, done, error, bus.LOCK, bus.READ, bus.WRITE, wr_ready, rd_valid}, 8'h00);
    endtask

    task automatic idle_step();
        @(negedge CLK);
        scramble(1'b0);
        bus.READDATAVALID = 1'b1;
        #1;
        check("idle_state", {busy, done, error, bus.LOCK, bus.READ, bus.WRITE, wr_ready, rd_valid}, 8'h00);
    endtask

    // mode 0: no stalls, 1: waitrequest x3 on beat 2 and wr_valid gap x2 on beat 3, 2: random
    task automatic run_write(input logic [31:0] addr, input int len_in, input logic [3:0] be, input int mode);
        int          len = (len_in == 0) ? 1 : len_in;
        logic [31:0] q[$];
        int          acc = 0, cyc = 0, streak = 0, ws = 0, gap = 0;
        for (int i = 0; i < len; i++) q.push_back($urandom);
        start_step(1'b0, addr, len_in, be);
        while (acc < len && cyc < 200) begin
            @(negedge CLK);
            scramble(mode == 2);
            wr_valid          = 1'b1;
            bus.WAITREQUEST   = 1'b0;
            bus.READDATAVALID = 1'($urandom_range(0, 1));
            bus.READDATA      = $urandom;
            if (mode == 1) begin
                if (acc == 1 && ws < 3) begin
                    bus.WAITREQUEST = 1'b1;
                    ws++;
                end else if (acc == 2 && gap < 2) begin
                    wr_valid = 1'b0;
                    gap++;
                end
            end else if (mode == 2 && streak < 8) begin
                wr_valid        = ($urandom_range(0, 3) != 0);
                bus.WAITREQUEST = ($urandom_range(0, 9) < 3);
            end
            wr_data = wr_valid ? q[acc] : $urandom;
            #1;
            burst_checks("wr", addr, len, be);
            check("wr_write",   bus.WRITE, wr_valid);
            check("wr_ready",   wr_ready, !bus.WAITREQUEST);
            check("wr_read",    bus.READ, 0);
            check("wr_rdvalid", rd_valid, 0);
            if (wr_valid) check("wr_data", bus.WRITEDATA, q[acc]);
            if (wr_valid && !bus.WAITREQUEST) begin
                acc++;
                streak = 0;
            end else begin
                streak++;
            end
            cyc++;
        end
        @(negedge CLK);
        scramble(1'b1);
        wr_valid          = 1'b1;
        bus.WAITREQUEST   = 1'b0;
        bus.READDATAVALID = 1'b1;
        #1;
        check("wr_done",     {done, error, busy, bus.LOCK, bus.WRITE, wr_ready}, 6'b101000);
        check("wr_done_rdv", rd_valid, 0);
    endtask

    task automatic run_read(input logic [31:0] addr, input int len_in, input logic [3:0] be,
                            input int n_wait, input bit same, input int gap_pct, input bit rand_start);
        int          len = (len_in == 0) ? 1 : len_in;
        logic [31:0] q[$];
        int          idx = 0, streak = 0;
        bit          pv;
        logic [31:0] pd;
        for (int i = 0; i < len; i++) q.push_back($urandom | 32'h1);
        start_step(1'b1, addr, len_in, be);
        for (int w = 0; w <= n_wait; w++) begin
            @(negedge CLK);
            scramble(rand_start);
            bus.WAITREQUEST   = (w < n_wait);
            bus.READDATAVALID = (w == n_wait) && same;
            bus.READDATA      = bus.READDATAVALID ? q[0] : $urandom;
            #1;
            burst_checks("rc", addr, len, be);
            check("rc_read",  bus.READ, 1);
            check("rc_write", {bus.WRITE, wr_ready}, 0);
            check("rc_rdv",   rd_valid, 0);
        end
        pv = same;
        pd = q[0];
        if (same) idx = 1;
        while (idx < len) begin
            @(negedge CLK);
            scramble(rand_start);
            bus.WAITREQUEST   = 1'($urandom_range(0, 1));
            bus.READDATAVALID = ($urandom_range(0, 99) >= gap_pct) || (streak >= 8);
            bus.READDATA      = bus.READDATAVALID ? q[idx] : $urandom;
            #1;
            burst_checks("rd", addr, len, be);
            check("rd_read",  {bus.READ, bus.WRITE}, 0);
            check("rd_valid", rd_valid, pv);
            if (pv) check("rd_data", rd_data, pd);
            pv = bus.READDATAVALID;
            if (pv) begin
                pd = q[idx];
                idx++;
                streak = 0;
            end else begin
                streak++;
            end
        end
        @(negedge CLK);
        scramble(1'b1);
        bus.READDATAVALID = 1'b1;
        bus.READDATA      = $urandom;
        #1;
        check("rd_done",       {done, error, busy, bus.LOCK, bus.READ, bus.WRITE}, 6'b101000);
        check("rd_last_valid", rd_valid, pv);
        check("rd_last_data",  rd_data, pd);
    endtask

    task automatic run_timeout(input logic [31:0] addr, input int len_in, input logic [3:0] be);
        start_step(1'b1, addr, len_in, be);
        for (int c = 1; c <= TIMEOUT + 1; c++) begin
            @(negedge CLK);
            scramble(1'b1);
            bus.WAITREQUEST   = 1'b1;
            bus.READDATAVALID = 1'b0;
            #1;
            if (c <= TIMEOUT) begin
                check("to_read", bus.READ, 1);
                check("to_stat", {busy, done, error}, 3'b100);
            end else begin
                check("to_done", {bus.READ, done, error, busy, bus.LOCK}, 5'b01110);
            end
        end
    endtask

    initial begin
        bus.WAITREQUEST   = 1'b0;
        bus.READDATAVALID = 1'b0;
        bus.READDATA      = '0;
        RESET_N           = 1'b0;
        repeat (3) @(negedge CLK);
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_BEEF;
        start    = 1'b1;
        #1;
        check_reset_zero("por");

        run_write(32'h0000_0100, 4, 4'hF, 0);
        run_write(32'h0000_0200, 4, 4'h3, 1);
        run_read (32'h0000_0300, 8, 4'hF, 2, 1'b0, 40, 1'b0);
        run_timeout(32'h0000_0400, 5, 4'hC);
        run_write(32'h0000_0500, 0, 4'h1, 0);
        run_read (32'h0000_0600, 0, 4'h2, 0, 1'b1, 0, 1'b0);
        run_read (32'h0000_0700, 3, 4'h8, 1, 1'b1, 50, 1'b1);

        for (int it = 0; it < 8; it++) begin
            logic [31:0] a  = $urandom;
            int          ln = $urandom_range(0, 15);
            logic [3:0]  be = 4'($urandom);
            if ($urandom_range(0, 1) == 1)
                run_read(a, ln, be, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 40, 1'b1);
            else
                run_write(a, ln, be, 2);
        end

        // Reset in the middle of a read burst, after two beats have landed.
        start_step(1'b1, 32'h0000_0800, 8, 4'hF);
        @(negedge CLK);
        scramble(1'b0);
        bus.WAITREQUEST   = 1'b0;
        bus.READDATAVALID = 1'b0;
        for (int b = 0; b < 2; b++) begin
            @(negedge CLK);
            bus.READDATAVALID = 1'b1;
            bus.READDATA      = $urandom | 32'h1;
        end
        @(negedge CLK);
        bus.READDATAVALID = 1'b0;
        wr_valid = 1'b1;
        wr_data  = $urandom | 32'h1;
        #1;
        check("pre_rst_lock", {busy, bus.LOCK}, 2'b11);
        RESET_N = 1'b0;
        #1;
        check_reset_zero("mid_rst");
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            start = 1'b1;
            bus.READDATAVALID = 1'b1;
            #1;
            check("rst_hold", {busy, done, error, rd_valid, bus.LOCK}, 5'b00000);
        end

        run_write(32'h0000_0900, 2, 4'h5, 0);
        idle_step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
